// File: rtl/fb_pkg.sv
// Shared types for the framebuffer reader.
// Pixel word, FIFO word and FSM state.
package fb_pkg;

  typedef logic [15:0] pixel_t;

  typedef struct packed {
    logic   sof;
    pixel_t pix;
  } fifo_word_t;

  localparam int HDISP_DEF = 640;
  localparam int VDISP_DEF = 480;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

endpackage

// File: rtl/wshb_if.sv
// Wishbone bus bundle, 32-bit address, 16-bit data.
// Clock and reset travel with the bus.
interface wshb_if (
  input logic clk,
  input logic rst
);

  logic [31:0] adr;
  logic [15:0] dat_ms;
  logic [15:0] dat_sm;
  logic [1:0]  sel;
  logic        we;
  logic        stb;
  logic        cyc;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;

  modport master (
    input  clk, rst, dat_sm, ack,
    output adr, dat_ms, sel, we,
    output stb, cyc, cti, bte
  );

  modport slave (
    input  clk, rst, adr, dat_ms, sel,
    input  we, stb, cyc, cti, bte,
    output dat_sm, ack
  );

endinterface

// File: rtl/fb_reader_fifo.sv
// Show-ahead FIFO between the bus and the pixel stream.
// Storage is left unreset; pointers and count are reset.
module fb_reader_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 17
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;

  assign empty  = (count == '0);
  assign do_pop = pop && !empty;
  assign dout   = mem[rd_ptr];

  // Write the incoming word at the tail.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Advance pointers; count tracks push minus pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  // The reader reserves a slot before each read.
  assert property (@(posedge clk) disable iff (rst)
    !(push && !do_pop && count == CW'(DEPTH)));

endmodule

// File: rtl/fb_reader.sv
// Wishbone framebuffer reader: raster reads into a FIFO.
// Optional bus fairness gap: FB_READER_FAIRPLAY_EN.
module fb_reader
  import fb_pkg::*;
#(
  parameter int HDISP = HDISP_DEF,
  parameter int VDISP = VDISP_DEF,
  parameter int DEPTH = 16
) (
  wshb_if.master      wshb_if_rd,
  output logic [15:0] pix_data,
  output logic        pix_sof,
  output logic        pix_valid,
  input  logic        pix_ready
);

  localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int FW = $bits(fifo_word_t);

  logic          clk;
  logic          rst;
  state_t        state;
  state_t        state_next;
  logic [XW-1:0] cpt_x;
  logic [YW-1:0] cpt_y;
  logic          ack;
  logic          pop;
  logic          empty;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          fp_limit;
  fifo_word_t    wr_word;
  fifo_word_t    head;
  logic [FW-1:0] head_bits;

  assign clk = wshb_if_rd.clk;
  assign rst = wshb_if_rd.rst;

  assign wshb_if_rd.we     = 1'b0;
  assign wshb_if_rd.sel    = 2'b11;
  assign wshb_if_rd.cti    = 3'b000;
  assign wshb_if_rd.bte    = 2'b00;
  assign wshb_if_rd.dat_ms = 16'h0000;
  assign wshb_if_rd.stb    = (state == REQ);
  assign wshb_if_rd.cyc    = (state == REQ);

  assign wshb_if_rd.adr =
    (32'(HDISP) * 32'(cpt_y) + 32'(cpt_x)) << 1;

  assign ack = wshb_if_rd.ack && (state == REQ);
  assign pop = pix_valid && pix_ready;

  assign count_next = count + CW'(ack) - CW'(pop);

  assign wr_word.sof = (cpt_x == '0) && (cpt_y == '0);
  assign wr_word.pix = wshb_if_rd.dat_sm;

`ifdef FB_READER_FAIRPLAY_EN
  logic [5:0] fp_cnt;

  assign fp_limit = ack && (fp_cnt == 6'd63);

  // Count acks in the current cyc; cleared as cyc falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fp_cnt <= '0;
    end else if (state_next != REQ) begin
      fp_cnt <= '0;
    end else if (ack) begin
      fp_cnt <= fp_cnt + 1'b1;
    end
  end
`else
  assign fp_limit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request only while a FIFO slot is free.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (count < CW'(DEPTH)) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (ack) begin
          if (count_next < CW'(DEPTH) && !fp_limit) begin
            state_next = REQ;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Raster position advances on every completed read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpt_x <= '0;
      cpt_y <= '0;
    end else if (ack) begin
      if (cpt_x == XW'(HDISP - 1)) begin
        cpt_x <= '0;
        if (cpt_y == YW'(VDISP - 1)) begin
          cpt_y <= '0;
        end else begin
          cpt_y <= cpt_y + 1'b1;
        end
      end else begin
        cpt_x <= cpt_x + 1'b1;
      end
    end
  end

  fb_reader_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ack),
    .din   (wr_word),
    .pop   (pop),
    .dout  (head_bits),
    .empty (empty),
    .count (count)
  );

  assign head      = fifo_word_t'(head_bits);
  assign pix_valid = !empty;
  assign pix_data  = pix_valid ? head.pix : 16'h0000;
  assign pix_sof   = pix_valid && head.sof;

endmodule

// File: doc/fb_reader.md
# fb_reader

Wishbone master that reads a HDISP×VDISP 16-bit framebuffer in raster order and delivers the pixels as a valid/ready stream to the video output path. It is the read-side counterpart of the pattern writer: same address mapping, same bus, opposite direction. An internal FIFO absorbs bus latency, and the block issues reads only while the FIFO has room.

## Interface
Parameters:
- HDISP, 640, pixels per line
- VDISP, 480, lines per frame
- DEPTH, 16, FIFO entries (power of two, ≥2)

Ports:
- wshb_if_rd.clk  in  1  single clock, via the wshb_if interface
- wshb_if_rd.rst  in  1  reset, asynchronous, active-high
- wshb_if_rd  wshb_if.master  –  Wishbone master modport: adr 32, dat_ms 16, dat_sm 16, sel 2, we, stb, cyc, cti, bte, ack
- pix_data  out  16  head-of-FIFO pixel
- pix_sof  out  1  head pixel is (x=0, y=0)
- pix_valid  out  1  FIFO not empty
- pix_ready  in  1  consumer accepts pixel

## Operation
- Constant outputs: we=0, sel=2'b11, cti=0, bte=0, dat_ms=0.
- adr = 2*(HDISP*cpt_y + cpt_x), zero-extended to 32 bits. cpt_x is $clog2(HDISP) bits wide; cpt_y is $clog2(VDISP) bits wide.
- FSM states: IDLE, REQ. stb = cyc = (state==REQ).
  - IDLE → REQ when count < DEPTH (and, with fairplay, no pause pending).
  - REQ → REQ on ack if count_next < DEPTH. Otherwise REQ → IDLE.
  - REQ without ack: hold stb, cyc and adr stable.
- On ack, the block writes {sof, dat_sm} into the FIFO. sof = (cpt_x==0 && cpt_y==0).
- On ack, cpt_x increments. When cpt_x==HDISP-1 it wraps to 0 and cpt_y increments. When cpt_y==VDISP-1 at that point, cpt_y also wraps to 0, so frames repeat continuously.
- At most one transfer is outstanding. Entering REQ only with count<DEPTH reserves one slot, so an ack never finds the FIFO full.
- FIFO is show-ahead. Pop on pix_valid && pix_ready.
- pix_data = pix_valid ? head : 0. pix_sof = pix_valid && head_sof.
- Simultaneous push and pop: count unchanged, both take effect.
- Pop with FIFO empty is ignored. Push with FIFO full is impossible by construction; an assertion flags it.

## Timing
- Reset (asynchronous, immediate) values: state=IDLE, stb=cyc=0, cpt_x=cpt_y=0 so adr=0, FIFO empty, count=0, pix_valid=0, pix_data=0, pix_sof=0.
- Reset mid-cycle: cyc drops at once and any outstanding read is abandoned. The first read after reset is adr 0.
- First read: stb rises on the first clock edge after reset deasserts.
- Back-to-back: stb stays high across acks. Slave ack on consecutive cycles gives one pixel per clock.
- Ack at edge N: pix_valid=1 from after edge N. adr shows the next address after edge N.
- count_next = count + push − pop. A pop on the same edge as the filling ack keeps state REQ.

## Configuration
- FB_READER_FAIRPLAY_EN defined:
  - A 6-bit counter counts acks within the current cyc.
  - After the 64th consecutive ack, the FSM is forced to IDLE for exactly one cycle (cyc=0), then resumes. The counter clears whenever cyc falls.
- FB_READER_FAIRPLAY_EN undefined: cyc stays high as long as the FIFO has room, and the counter logic is absent.

## Structure
- Package fb_pkg holds:
  - typedef pixel_t (logic [15:0])
  - typedef fifo_word_t (struct {sof, pixel_t})
  - localparam defaults HDISP_DEF=640, VDISP_DEF=480
  - typedef state_t (IDLE, REQ)
- Sub-module fb_reader_fifo: synchronous show-ahead FIFO with parameters DEPTH and width.
  - Ports: clk, rst, push, din, pop, dout, empty, count.
  - Storage is not reset; pointers and count are.
- Top level holds the FSM, the address counters and the optional fairplay counter.

## Test plan
- Reset, slave acks every cycle, pix_ready=1 → adr sequence 0,2,4,…; pixels stream at 1/clock; pix_sof=1 only on the first pixel.
- pix_ready=0 → exactly DEPTH=16 acks, then cyc=0 with pix_valid=1. Raise pix_ready for one pop → exactly one new read issued.
- HDISP=4, VDISP=3 → adr goes 0..22, wraps to 0, and pix_sof reappears on the 13th pixel.
- Slave inserts 3 wait states per access → adr and stb are stable while ack=0, and each dat_sm appears on pix_data in order.
- Assert rst while stb=1 mid-frame → cyc=0 immediately; after release the first adr is 0 and the FIFO is empty.
- FB_READER_FAIRPLAY_EN defined, continuous ack → cyc low for one cycle after every 64 acks. Undefined → cyc never drops.
